// File: rtl/fft_bitrev_buffer.sv
// Ping-pong frame buffer feeding the FFT: natural-order real samples in, bit-reversed complex words out.
// Optional FFT_BUF_FRAME_CNT_EN adds a 16-bit delivered-frame counter on buf_frame_out.
module fft_bitrev_buffer #(
  parameter int DATA_WIDTH = 12,
  parameter int FFT_POINTS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  buf_ready_in,
  input  logic                  buf_valid_in,
  input  logic [DATA_WIDTH-1:0] buf_data_in,
  input  logic                  buf_ready_out,
  output logic                  buf_valid_out,
  output logic [DATA_WIDTH-1:0] buf_re_out,
  output logic [DATA_WIDTH-1:0] buf_im_out,
`ifdef FFT_BUF_FRAME_CNT_EN
  output logic [15:0]           buf_frame_out,
`endif
  output logic                  buf_last_out
);

  localparam int LOG2_POINTS = $clog2(FFT_POINTS);
  localparam logic [LOG2_POINTS-1:0] LAST_IDX =
    LOG2_POINTS'(FFT_POINTS - 1);
  localparam logic [LOG2_POINTS-1:0] IDX_ONE = LOG2_POINTS'(1);

  if ((FFT_POINTS < 2) ||
      ((FFT_POINTS & (FFT_POINTS - 1)) != 0)) begin : g_bad_points
    $error("FFT_POINTS must be a power of 2 and at least 2");
  end

  function automatic logic [LOG2_POINTS-1:0] bitrev(
    input logic [LOG2_POINTS-1:0] i
  );
    logic [LOG2_POINTS-1:0] r;
    r = '0;
    for (int k = 0; k < LOG2_POINTS; k++) begin
      r[LOG2_POINTS-1-k] = i[k];
    end
    return r;
  endfunction

  logic [DATA_WIDTH-1:0]  mem_q [2][FFT_POINTS];
  logic [DATA_WIDTH-1:0]  mem_d [2][FFT_POINTS];
  logic [1:0]             full_q, full_d;
  logic                   wr_bank_q, wr_bank_d;
  logic                   rd_bank_q, rd_bank_d;
  logic [LOG2_POINTS-1:0] wr_idx_q, wr_idx_d;
  logic [LOG2_POINTS-1:0] rd_idx_q, rd_idx_d;
  logic [LOG2_POINTS-1:0] rd_addr;
  logic                   in_hs;
  logic                   out_hs;
  logic                   out_last;

  assign buf_ready_in  = !full_q[wr_bank_q] && !rst;
  assign buf_valid_out = full_q[rd_bank_q];
  assign rd_addr       = bitrev(rd_idx_q);
  assign out_last      = (rd_idx_q == LAST_IDX);
  assign in_hs         = buf_valid_in && buf_ready_in;
  assign out_hs        = buf_valid_out && buf_ready_out;

  assign buf_re_out   = buf_valid_out ? mem_q[rd_bank_q][rd_addr] : '0;
  assign buf_im_out   = '0;
  assign buf_last_out = buf_valid_out && out_last;

  always_comb begin
    mem_d     = mem_q;
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    if (in_hs) begin
      mem_d[wr_bank_q][wr_idx_q] = buf_data_in;
      if (wr_idx_q == LAST_IDX) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_idx_d          = '0;
      end else begin
        wr_idx_d = wr_idx_q + IDX_ONE;
      end
    end
    // Reader always targets the other bank when both frames end together.
    if (out_hs) begin
      if (out_last) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
        rd_idx_d          = '0;
      end else begin
        rd_idx_d = rd_idx_q + IDX_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef FFT_BUF_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (out_hs && out_last) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign buf_frame_out = frame_cnt_q;
`endif

endmodule

// File: tb/tb_fft_bitrev_buffer.sv
// Scoreboard bench for fft_bitrev_buffer: frame-level reference model,
// negedge monitor comparing every output handshake and flow-control state.
module tb_fft_bitrev_buffer;

  localparam int DW = 12;
  localparam int NP = 8;
  localparam int LG = 3;

  logic          clk;
  logic          rst;
  logic          buf_ready_in;
  logic          buf_valid_in;
  logic [DW-1:0] buf_data_in;
  logic          buf_ready_out;
  logic          buf_valid_out;
  logic [DW-1:0] buf_re_out;
  logic [DW-1:0] buf_im_out;
  logic          buf_last_out;
`ifdef FFT_BUF_FRAME_CNT_EN
  logic [15:0]   buf_frame_out;
`endif

  fft_bitrev_buffer #(.DATA_WIDTH(DW), .FFT_POINTS(NP)) dut (
    .clk           (clk),
    .rst           (rst),
    .buf_ready_in  (buf_ready_in),
    .buf_valid_in  (buf_valid_in),
    .buf_data_in   (buf_data_in),
    .buf_ready_out (buf_ready_out),
    .buf_valid_out (buf_valid_out),
    .buf_re_out    (buf_re_out),
    .buf_im_out    (buf_im_out),
`ifdef FFT_BUF_FRAME_CNT_EN
    .buf_frame_out (buf_frame_out),
`endif
    .buf_last_out  (buf_last_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] re;
    logic          last;
  } exp_t;

  exp_t          exp_q [$];
  logic [DW-1:0] cur_q [$];
  int            nfull;
  int            n_cmp;
  int            n_err;
  int            exp_frames;
  logic          rst_prev;
  logic          hold_v;
  logic [DW-1:0] hold_re;
  logic          hold_last;
  logic          rnd_ready;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic int rev(input int i);
    int r;
    r = 0;
    for (int k = 0; k < LG; k++) r = r * 2 + ((i >> k) & 1);
    return r;
  endfunction

  // Monitor and reference model: check state now, then apply the events
  // that the coming posedge will commit.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      chk("ready_in_in_reset", {31'd0, buf_ready_in}, 0);
      if (rst_prev) begin
        chk("reset_valid", {31'd0, buf_valid_out}, 0);
        chk("reset_re", {20'd0, buf_re_out}, 0);
        chk("reset_last", {31'd0, buf_last_out}, 0);
`ifdef FFT_BUF_FRAME_CNT_EN
        chk("reset_frames", {16'd0, buf_frame_out}, 0);
`endif
      end
      exp_q.delete();
      cur_q.delete();
      nfull = 0;
      exp_frames = 0;
      hold_v = 1'b0;
    end else begin
      chk("ready_in", {31'd0, buf_ready_in}, (nfull < 2) ? 1 : 0);
      chk("valid_out", {31'd0, buf_valid_out}, (nfull > 0) ? 1 : 0);
      chk("im_out", {20'd0, buf_im_out}, 0);
      if (!buf_valid_out) begin
        chk("idle_re", {20'd0, buf_re_out}, 0);
        chk("idle_last", {31'd0, buf_last_out}, 0);
      end
      if (hold_v) begin
        chk("stall_valid", {31'd0, buf_valid_out}, 1);
        chk("stall_re", {20'd0, buf_re_out}, {20'd0, hold_re});
        chk("stall_last", {31'd0, buf_last_out}, {31'd0, hold_last});
      end
`ifdef FFT_BUF_FRAME_CNT_EN
      chk("frame_cnt", {16'd0, buf_frame_out}, exp_frames & 32'hFFFF);
`endif
      if (buf_valid_out && buf_ready_out) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_re", {20'd0, buf_re_out}, {20'd0, e.re});
          chk("out_last", {31'd0, buf_last_out}, {31'd0, e.last});
          if (e.last) begin
            nfull--;
            exp_frames++;
          end
        end
      end
      hold_v    = buf_valid_out && !buf_ready_out;
      hold_re   = buf_re_out;
      hold_last = buf_last_out;
      if (buf_valid_in && buf_ready_in) begin
        cur_q.push_back(buf_data_in);
        if (cur_q.size() == NP) begin
          for (int j = 0; j < NP; j++) begin
            e.re   = cur_q[rev(j)];
            e.last = (j == NP - 1);
            exp_q.push_back(e);
          end
          cur_q.delete();
          nfull++;
        end
      end
    end
    rst_prev = rst;
  end

  always @(posedge clk) begin
    #1;
    if (rnd_ready) buf_ready_out = 1'($urandom_range(0, 1));
  end

  task automatic send(input logic [DW-1:0] d);
    int   b;
    logic acc;
    b   = 0;
    acc = 1'b0;
    buf_valid_in = 1'b1;
    buf_data_in  = d;
    while (!acc && b < 2000) begin
      acc = buf_ready_in;
      @(posedge clk);
      #1;
      b++;
    end
    if (!acc) chk("send_timeout", 1, 0);
    buf_valid_in = 1'b0;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (exp_q.size() > 0 && b < 1000) begin
      @(posedge clk);
      b++;
    end
    #1;
    if (exp_q.size() > 0) chk("drain_timeout", 1, 0);
  endtask

  task automatic do_reset(input int cyc);
    rst = 1'b1;
    repeat (cyc) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] ext [NP];
    n_cmp = 0;
    n_err = 0;
    nfull = 0;
    exp_frames = 0;
    rst_prev = 1'b0;
    hold_v = 1'b0;
    rnd_ready = 1'b0;
    rst = 1'b1;
    buf_valid_in = 1'b0;
    buf_data_in = '0;
    buf_ready_out = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 1; i <= 8; i++) send(DW'(i));
    drain();
    repeat (3) @(posedge clk);
    #1;

    for (int i = 1; i <= 24; i++) send(DW'(i));
    drain();

    ext = '{12'h800, 12'h7FF, 12'h000, 12'hFFF,
            12'h001, 12'hFFE, 12'h002, 12'hFFD};
    for (int i = 0; i < NP; i++) send(ext[i]);
    drain();

    buf_ready_out = 1'b0;
    fork
      begin
        for (int i = 1; i <= 20; i++) send(DW'(i));
      end
      begin
        repeat (40) @(posedge clk);
        #1;
        buf_ready_out = 1'b1;
      end
    join
    drain();

    rnd_ready = 1'b1;
    for (int i = 0; i < 44; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send(DW'($urandom));
    end
    drain();
    rnd_ready = 1'b0;
    #1;
    buf_ready_out = 1'b1;

    for (int i = 0; i < 5; i++) send(DW'(100 + i));
    do_reset(2);
    for (int i = 10; i <= 17; i++) send(DW'(i));
    drain();

    repeat (5) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fft_bitrev_buffer.md
Name: fft_bitrev_buffer

Overview:
- Input framing stage directly upstream of the radix-2 FFT core.
- Accepts real signed samples serially in natural order over a valid/ready handshake and collects FFT_POINTS samples per frame.
- Streams each completed frame to the FFT as complex words (im = 0) in bit-reversed index order, with a last-of-frame flag.
- Ping-pong double buffer: one bank fills while the other drains.

Parameters:
- DATA_WIDTH, 12: sample width, signed two's complement.
- FFT_POINTS, 8: frame length; power of 2, minimum 2.
- LOG2_POINTS (localparam), $clog2(FFT_POINTS): index width.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous active-high reset.
- buf_ready_in  output  1  block can accept a sample.
- buf_valid_in  input  1  buf_data_in is valid.
- buf_data_in  input  DATA_WIDTH  signed real sample.
- buf_ready_out  input  1  downstream FFT accepts an output word.
- buf_valid_out  output  1  buf_re_out/buf_im_out valid.
- buf_re_out  output  DATA_WIDTH  real part, signed.
- buf_im_out  output  DATA_WIDTH  imaginary part, always 0.
- buf_last_out  output  1  high with the final word of a frame.

Behaviour:
- Storage: 2 banks × FFT_POINTS × DATA_WIDTH registers; per-bank full flag.
- Write side: wr_bank and wr_idx (LOG2_POINTS bits).
  - buf_ready_in = !full[wr_bank] && !rst.
  - On in-handshake (valid_in && ready_in): bank[wr_bank][wr_idx] <= data_in; wr_idx++.
  - When wr_idx == FFT_POINTS-1 at handshake: full[wr_bank] <= 1, wr_bank toggles, wr_idx <= 0.
- Read side: rd_bank and rd_idx.
  - buf_valid_out = full[rd_bank].
  - buf_re_out = bank[rd_bank][bitrev(rd_idx)] when valid, else 0. buf_im_out = 0 always.
  - buf_last_out = valid_out && (rd_idx == FFT_POINTS-1).
  - On out-handshake (valid_out && ready_out): rd_idx++.
  - At the last word: full[rd_bank] <= 0, rd_bank toggles, rd_idx <= 0.
- Outputs change only on clock edges because they are driven from registered pointers and storage. Output data, valid and last are held stable while valid_out && !ready_out.
- Latency: first word of a frame is valid on the cycle after the frame's final input handshake. With both sides always ready, throughput is 1 sample/cycle sustained, with no bubbles between frames.
- Full condition: both banks full → ready_in = 0 until the reader finishes a frame. ready_in rises the cycle after the last-word out-handshake.
- Empty condition: both banks empty → valid_out = 0, outputs 0.
- Simultaneous frame completion on the write and read sides in the same cycle: flags update independently; they always target different banks.
- Wrap-around: wr_idx and rd_idx wrap to 0 only at frame end. Bank pointers toggle 0↔1.
- Reset values: full[1:0] = 0, wr_bank = rd_bank = 0, wr_idx = rd_idx = 0. Result: ready_in = 0 during rst, then 1; valid_out = 0; re/im = 0; last = 0. Storage is not reset.
- Reset mid-operation discards any partial or buffered frames. The next accepted sample is index 0 of a new frame.
- bitrev(i): bit k of i maps to bit LOG2_POINTS-1-k.
- Assertion (sim only): FFT_POINTS is a power of 2 and ≥ 2.

Optional Feature:
- Macro: FFT_BUF_FRAME_CNT_EN.
- Defined:
  - Adds output port buf_frame_out, 16 bits.
  - Counts frames fully delivered downstream: increments on the last-word out-handshake.
  - Wraps 16'hFFFF → 0; reset to 0.
  - The value is stable between increments.
- Not defined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- FFT_POINTS=8, feed 1..8, ready_out=1 → outputs re = 1,5,3,7,2,6,4,8; im = 0; last only on 8. First valid_out is 1 cycle after the 8th input handshake.
- Continuous input 1..24, ready_out=1 → three frames back to back, each bit-reversed; ready_in never drops; no valid_out gaps after the first frame.
- ready_out=0, feed 20 samples → ready_in drops after 16 accepted. Raise ready_out → after 8 out-handshakes ready_in returns; samples 17..20 are accepted and held.
- ready_out toggling randomly mid-frame → data and last stay stable while stalled; no loss or duplication.
- Signed extremes: feed -2048, 2047, 0, -1, 1, -2, 2, -3 → outputs -2048, 1, 0, 2, 2047, -2, -1, -3, with no sign corruption.
- Reset after 5 input samples, then feed 10..17 → outputs 10,14,12,16,11,15,13,17; the pre-reset samples are never output. With FFT_BUF_FRAME_CNT_EN: frame count 0 after reset, 1 after the frame drains.
